control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/instr_decode.sv | 20 ++
 rtl/control_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants and control sequencer state types shared by the sequencer and the datapath ALU.
//   No ports. OP_* are the 5-bit IR[31:27] opcodes, state_e is the control step,
//   seq_state_t is the full sequencer state register contents.
package cpu_pkg;
    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_HALT
    } state_e;

    // t1_held marks T1 cycles after the first one, so PCin fires only once per fetch.
    typedef struct packed {
        state_e st;
        logic   t1_held;
    } seq_state_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: classifies an opcode as binary ALU, unary ALU, or unsupported.
//   in  opcode[4:0]  IR[31:27]
//   out is_binary    two-operand ALU instruction
//   out is_unary     one-operand ALU instruction
//   out is_legal     either of the above
module instr_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       is_binary,
    output logic       is_unary,
    output logic       is_legal
);
    always_comb begin
        is_binary = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
                                   OP_ROL, OP_SHR, OP_SHRA, OP_SHL};
        is_unary  = opcode inside {OP_NEG, OP_NOT};
        is_legal  = is_binary || is_unary;
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit stepping fetch (T0-T2) and ALU execute/writeback (T3-T5).
//   in  Clock, Resetn (async, active low), Run, Stall, IR[31:0]
//   out datapath strobes PCout..Read, register controls Gra..Rout, op[4:0],
//       Busy (not IDLE/HALT), Done (writeback pulse), Illegal (HALT reached)
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic        Stall,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  op,
    output logic        Busy,
    output logic        Done,
    output logic        Illegal
);
    seq_state_t seq_q, seq_d;
    logic       is_binary, is_unary, is_legal;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    instr_decode u_dec (
        .opcode    (opcode),
        .is_binary (is_binary),
        .is_unary  (is_unary),
        .is_legal  (is_legal)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) seq_q <= '{st: ST_IDLE, t1_held: 1'b0};
        else         seq_q <= seq_d;
    end

    always_comb begin
        seq_d   = seq_q;
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        op      = OP_NONE;
        Done    = 1'b0;
        Illegal = 1'b0;
        Busy    = !(seq_q.st inside {ST_IDLE, ST_HALT});
        case (seq_q.st)
            ST_IDLE: seq_d.st = Run ? ST_T0 : ST_IDLE;
            ST_T0: begin
                {PCout, MARin, IncPC, Zin} = '1;
                seq_d = '{st: ST_T1, t1_held: 1'b0};
            end
            ST_T1: begin
                {Zlowout, Read, MDRin} = '1;
                PCin  = !seq_q.t1_held;
                seq_d = Stall ? '{st: ST_T1, t1_held: 1'b1} : '{st: ST_T2, t1_held: 1'b0};
            end
            ST_T2: begin
                {MDRout, IRin} = '1;
                seq_d.st = ST_T3;
            end
            ST_T3: begin
                // Unsupported opcodes leave T3 with every strobe low.
                {Grb, Rout} = {2{is_legal}};
                Yin      = is_binary;
                Zin      = is_unary;
                op       = is_unary ? opcode : OP_NONE;
                seq_d.st = is_legal ? ST_T4 : ST_HALT;
            end
            ST_T4: begin
                {Grc, Zin}               = {2{is_binary}};
                Rout                     = is_binary;
                op                       = is_binary ? opcode : OP_NONE;
                {Zlowout, Gra, Rin, Done} = {4{is_unary}};
                // IR is expected stable here; a vanished opcode is treated as illegal.
                seq_d.st = is_binary ? ST_T5 : is_unary ? (Run ? ST_T0 : ST_IDLE) : ST_HALT;
            end
            ST_T5: begin
                {Zlowout, Gra, Rin, Done} = '1;
                seq_d.st = Run ? ST_T0 : ST_IDLE;
            end
            ST_HALT: Illegal = 1'b1;
            default: seq_d = '{st: ST_IDLE, t1_held: 1'b0};
        endcase
    end
endmodule
